pzcorebus_memory_responder: RTL and testbench
=============================================

// Module: pzcorebus_memory_responder
// PURPOSE
//  Terminating slave endpoint for pzcorebus, used as the responder at the end of a connector chain.
//  Accepts READ / WRITE / WRITE_NON_POSTED commands and services them from an internal flop array.
//  Returns read data bursts and non-posted write acknowledgements.
//  Used as a bus-fabric test target and as a small on-chip scratch/config store.
// PARAMETERS
//  BUS_CONFIG   pzcorebus_config default  bus profile: widths of data, address, ID and length.
//  DEPTH        int 64                    number of DATA_WIDTH words stored; power of two, >= 2.
//  BASE_ADDRESS int 0                     byte address of word 0; must be aligned to DEPTH*DATA_WIDTH/8.
// PORTS
//  i_clk     input  1          clock; all logic rising-edge.
//  i_rst     input  1          reset, synchronous, active-high.
//  slave_if  pzcorebus_if.slave  n/a   command/data in; response out.
// BEHAVIOUR
//  Reset:
//  - i_clk is the only clock; i_rst is a synchronous, active-high reset.
//  - Outputs on reset: scmd_accept=1, sdata_accept=0, sresp_valid=0, sresp/sid/serror/sdata/sresp_last=0.
//  - State returns to IDLE. Memory contents are not reset.
//  - Assertion mid-burst abandons the burst. No response is emitted for it.
//  Addressing:
//  - Word index = maddr[ADDR_LSB +: clog2(DEPTH)], where ADDR_LSB = clog2(DATA_WIDTH/8).
//  - Burst beats increment the index and wrap modulo DEPTH.
//  - Burst length = mlength; mlength==0 encodes MAX_LENGTH.
//  - Out of range: maddr - BASE_ADDRESS >= DEPTH*DATA_WIDTH/8. Such a command is flagged with err=1.
//  FSM {IDLE, WRITE_DATA, WRITE_RESP, READ_RESP}:
//  - IDLE: scmd_accept=1, sdata_accept=0.
//    On accept (mcmd_valid & scmd_accept), latch index, count, mid, err.
//    WRITE / WRITE_NON_POSTED -> WRITE_DATA. READ -> READ_RESP. Any other mcmd -> READ_RESP with err=1, 1 beat.
//  - WRITE_DATA: scmd_accept=0, sdata_accept=1.
//    Each mdata_valid beat writes mdata under mdata_byteenable, unless err=1 (write dropped).
//    Each beat increments index and decrements count.
//    Beat ends the burst when mdata_last=1 OR count reaches 1, whichever is first.
//    Posted write -> IDLE. Non-posted -> WRITE_RESP.
//  - WRITE_RESP: sresp_valid=1, sresp=RESPONSE, sid=latched mid, serror=err, sresp_last=1.
//    Hold until mresp_accept, then -> IDLE.
//  - READ_RESP: sresp_valid=1, sresp=RESPONSE_WITH_DATA.
//    sdata = mem[index], or 0 if err=1. sid=mid, serror=err.
//    sresp_last=1 on the final beat. Advance index/count only on mresp_accept.
//    After the final accept -> IDLE.
//  Timing and handshake rules:
//  - Response outputs are registered. First read beat is valid the cycle after command accept (latency 1).
//  - Back-to-back: the IDLE cycle after a completed response is mandatory. Max one command in flight.
//  - Response signals stay stable while sresp_valid=1 and mresp_accept=0.
//  - Read-after-write to the same word returns the new data.
//  - Data beats arriving in IDLE are not accepted (sdata_accept=0).
// STRUCTURE
//  - pzcorebus_pkg provides pzcorebus_command_type, pzcorebus_response_type and the config struct. Reuse them.
//  - FSM state enum is local to the module.
//  - Sub-module pzcorebus_memory_responder_ram: DEPTH x DATA_WIDTH flop array.
//    One write port with byte enables and one asynchronous read port.
// TESTING
//  - Posted WRITE maddr=BASE+0x10, mlength=2, data 0xA5A5/0x5A5A, then READ same maddr, mlength=2.
//    -> 2 beats 0xA5A5, 0x5A5A; sresp_last on beat 2.
//  - WRITE_NON_POSTED mid=3, mlength=1 -> exactly one RESPONSE, sid=3, serror=0, sresp_last=1.
//  - READ index DEPTH-1, mlength=3 -> beats read words DEPTH-1, 0, 1 (wrap).
//  - READ maddr beyond range -> beats sdata=0, serror=1.
//    WRITE beyond range -> memory unchanged, verified by a later read.
//  - READ mlength=4 with mresp_accept low 5 cycles on beat 2 -> beat 2 outputs held stable. 4 beats total, in order.
//  - i_rst asserted during beat 3 of an 8-beat read -> next cycle sresp_valid=0, scmd_accept=1.
//    A new READ then completes normally.

Source files
------------

// File: rtl/pzcorebus_pkg.sv
// Shared pzcorebus definitions: bus profile, command and response encodings.
package pzcorebus_pkg;

  typedef struct packed {
    int data_width;
    int address_width;
    int id_width;
    int length_width;
    int max_length;
  } pzcorebus_config;

  localparam pzcorebus_config PZCOREBUS_DEFAULT_CONFIG = '{
    data_width:    32,
    address_width: 32,
    id_width:      4,
    length_width:  4,
    max_length:    16
  };

  typedef enum logic [2:0] {
    PZCOREBUS_NULL_COMMAND     = 3'b000,
    PZCOREBUS_READ             = 3'b001,
    PZCOREBUS_WRITE            = 3'b010,
    PZCOREBUS_WRITE_NON_POSTED = 3'b011,
    PZCOREBUS_ATOMIC           = 3'b100,
    PZCOREBUS_MESSAGE          = 3'b101
  } pzcorebus_command_type;

  typedef enum logic [1:0] {
    PZCOREBUS_NULL_RESPONSE        = 2'b00,
    PZCOREBUS_RESPONSE             = 2'b01,
    PZCOREBUS_RESPONSE_WITH_DATA   = 2'b10
  } pzcorebus_response_type;

  function automatic logic is_write_command(pzcorebus_command_type cmd);
    return (cmd == PZCOREBUS_WRITE) || (cmd == PZCOREBUS_WRITE_NON_POSTED);
  endfunction

endpackage

// File: rtl/pzcorebus_if.sv
// pzcorebus point-to-point link: command, write data and response channels.
interface pzcorebus_if
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG = PZCOREBUS_DEFAULT_CONFIG
);
  localparam int DW  = BUS_CONFIG.data_width;
  localparam int AW  = BUS_CONFIG.address_width;
  localparam int IDW = BUS_CONFIG.id_width;
  localparam int LW  = BUS_CONFIG.length_width;

  logic                   mcmd_valid;
  logic                   scmd_accept;
  pzcorebus_command_type  mcmd;
  logic [IDW-1:0]         mid;
  logic [AW-1:0]          maddr;
  logic [LW-1:0]          mlength;

  logic                   mdata_valid;
  logic                   sdata_accept;
  logic [DW-1:0]          mdata;
  logic [DW/8-1:0]        mdata_byteenable;
  logic                   mdata_last;

  logic                   sresp_valid;
  logic                   mresp_accept;
  pzcorebus_response_type sresp;
  logic [IDW-1:0]         sid;
  logic                   serror;
  logic [DW-1:0]          sdata;
  logic                   sresp_last;

  modport master (
    output mcmd_valid, mcmd, mid, maddr, mlength,
    input  scmd_accept,
    output mdata_valid, mdata, mdata_byteenable, mdata_last,
    input  sdata_accept,
    input  sresp_valid, sresp, sid, serror, sdata, sresp_last,
    output mresp_accept
  );

  modport slave (
    input  mcmd_valid, mcmd, mid, maddr, mlength,
    output scmd_accept,
    input  mdata_valid, mdata, mdata_byteenable, mdata_last,
    output sdata_accept,
    output sresp_valid, sresp, sid, serror, sdata, sresp_last,
    input  mresp_accept
  );

endinterface

// File: rtl/pzcorebus_memory_responder_ram.sv
// DEPTH x DATA_WIDTH flop array: one byte-enabled write port, one asynchronous read port.
module pzcorebus_memory_responder_ram #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32
)(
  input  logic                       clk,
  input  logic                       write_enable,
  input  logic [$clog2(DEPTH)-1:0]   write_index,
  input  logic [DATA_WIDTH-1:0]      write_data,
  input  logic [DATA_WIDTH/8-1:0]    write_byteenable,
  input  logic [$clog2(DEPTH)-1:0]   read_index,
  output logic [DATA_WIDTH-1:0]      read_data
);
  localparam int unsigned BEW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_enable) begin
      for (int unsigned b = 0; b < BEW; b++) begin
        if (write_byteenable[b]) begin
          mem[write_index][8*b +: 8] <= write_data[8*b +: 8];
        end
      end
    end
  end

  assign read_data = mem[read_index];

endmodule

// File: rtl/pzcorebus_memory_responder.sv
// Terminating pzcorebus slave: services READ / WRITE / WRITE_NON_POSTED from a local flop array.
module pzcorebus_memory_responder
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG   = PZCOREBUS_DEFAULT_CONFIG,
  parameter int              DEPTH        = 64,
  parameter int              BASE_ADDRESS = 0
)(
  input  logic       i_clk,
  input  logic       i_rst,
  pzcorebus_if.slave slave_if
);
  localparam int DW       = BUS_CONFIG.data_width;
  localparam int AW       = BUS_CONFIG.address_width;
  localparam int IDW      = BUS_CONFIG.id_width;
  localparam int LW       = BUS_CONFIG.length_width;
  localparam int MAX_LEN  = BUS_CONFIG.max_length;
  localparam int BEW      = DW / 8;
  localparam int ADDR_LSB = $clog2(BEW);
  localparam int IW       = $clog2(DEPTH);
  localparam int CW       = $clog2(MAX_LEN + 1);
  localparam int SIZE     = DEPTH * BEW;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_DATA,
    WRITE_RESP,
    READ_RESP
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [IW-1:0]  index;
  logic [CW-1:0]  count;
  logic [IDW-1:0] id;
  logic           err;
  logic           posted;

  logic [AW-1:0]  offset;
  logic           out_of_range;
  logic [CW-1:0]  burst_length;
  logic           final_beat;
  logic           write_enable;
  logic [DW-1:0]  read_data;

  assign offset       = slave_if.maddr - AW'(BASE_ADDRESS);
  assign out_of_range = offset >= AW'(SIZE);
  assign burst_length = (slave_if.mlength == '0) ? CW'(MAX_LEN) : CW'(slave_if.mlength);
  assign final_beat   = count == CW'(1);
  assign write_enable = (state == WRITE_DATA) && slave_if.mdata_valid && !err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Responses are decoded from the state and latched command fields, so every
  // response output is zero outside a response state and stable while stalled.
  always_comb begin
    state_next            = state;
    slave_if.scmd_accept  = 1'b0;
    slave_if.sdata_accept = 1'b0;
    slave_if.sresp_valid  = 1'b0;
    slave_if.sresp        = PZCOREBUS_NULL_RESPONSE;
    slave_if.sid          = '0;
    slave_if.serror       = 1'b0;
    slave_if.sdata        = '0;
    slave_if.sresp_last   = 1'b0;
    case (state)
      IDLE: begin
        slave_if.scmd_accept = 1'b1;
        if (slave_if.mcmd_valid) begin
          state_next = is_write_command(slave_if.mcmd) ? WRITE_DATA : READ_RESP;
        end
      end
      WRITE_DATA: begin
        slave_if.sdata_accept = 1'b1;
        if (slave_if.mdata_valid && (slave_if.mdata_last || final_beat)) begin
          state_next = posted ? IDLE : WRITE_RESP;
        end
      end
      WRITE_RESP: begin
        slave_if.sresp_valid = 1'b1;
        slave_if.sresp       = PZCOREBUS_RESPONSE;
        slave_if.sid         = id;
        slave_if.serror      = err;
        slave_if.sresp_last  = 1'b1;
        if (slave_if.mresp_accept) begin
          state_next = IDLE;
        end
      end
      READ_RESP: begin
        slave_if.sresp_valid = 1'b1;
        slave_if.sresp       = PZCOREBUS_RESPONSE_WITH_DATA;
        slave_if.sid         = id;
        slave_if.serror      = err;
        slave_if.sdata       = err ? '0 : read_data;
        slave_if.sresp_last  = final_beat;
        if (slave_if.mresp_accept && final_beat) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      index  <= '0;
      count  <= '0;
      id     <= '0;
      err    <= 1'b0;
      posted <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (slave_if.mcmd_valid) begin
            index  <= slave_if.maddr[ADDR_LSB +: IW];
            id     <= slave_if.mid;
            posted <= slave_if.mcmd == PZCOREBUS_WRITE;
            if (is_write_command(slave_if.mcmd) || (slave_if.mcmd == PZCOREBUS_READ)) begin
              count <= burst_length;
              err   <= out_of_range;
            end else begin
              // Unsupported commands get a single error beat
              count <= CW'(1);
              err   <= 1'b1;
            end
          end
        end
        WRITE_DATA: begin
          if (slave_if.mdata_valid) begin
            index <= index + 1'b1;
            count <= count - 1'b1;
          end
        end
        READ_RESP: begin
          if (slave_if.mresp_accept && !final_beat) begin
            index <= index + 1'b1;
            count <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  pzcorebus_memory_responder_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW)
  ) u_ram (
    .clk              (i_clk),
    .write_enable     (write_enable),
    .write_index      (index),
    .write_data       (slave_if.mdata),
    .write_byteenable (slave_if.mdata_byteenable),
    .read_index       (index),
    .read_data        (read_data)
  );

endmodule

// File: tb/tb_pzcorebus_memory_responder.sv
// Directed bench for pzcorebus_memory_responder: vector table plus multi-cycle sequences.
module tb_pzcorebus_memory_responder;
  import pzcorebus_pkg::*;

  localparam pzcorebus_config CFG  = PZCOREBUS_DEFAULT_CONFIG;
  localparam logic [31:0]     BASE = 32'h0000_1000;
  localparam int              NVEC = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  pzcorebus_if #(.BUS_CONFIG(CFG)) bus ();

  pzcorebus_memory_responder #(
    .BUS_CONFIG   (CFG),
    .DEPTH        (16),
    .BASE_ADDRESS (32'h0000_1000)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .slave_if (bus.slave)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  id;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic logic [31:0] waddr(input int n);
    return BASE + 32'(n * 4);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_cmd(input pzcorebus_command_type cmd, input logic [31:0] addr,
                          input logic [3:0] lenf, input logic [3:0] id);
    int n = 0;
    @(negedge clk);
    bus.mcmd_valid = 1'b1;
    bus.mcmd       = cmd;
    bus.maddr      = addr;
    bus.mlength    = lenf;
    bus.mid        = id;
    while (!bus.scmd_accept && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("cmd_accept_timeout", 64'(bus.scmd_accept), 64'd1);
    @(posedge clk);
    #1 bus.mcmd_valid = 1'b0;
  endtask

  task automatic send_data(input logic [31:0] data, input logic [3:0] be, input logic last);
    int n = 0;
    @(negedge clk);
    bus.mdata_valid      = 1'b1;
    bus.mdata            = data;
    bus.mdata_byteenable = be;
    bus.mdata_last       = last;
    while (!bus.sdata_accept && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("data_accept_timeout", 64'(bus.sdata_accept), 64'd1);
    @(posedge clk);
    #1 bus.mdata_valid = 1'b0;
  endtask

  task automatic recv_beat(input string nm, input pzcorebus_response_type er, input logic [3:0] eid,
                           input logic eerr, input logic elast, input logic chk_data,
                           input logic [31:0] edata);
    int n = 0;
    @(negedge clk);
    while (!bus.sresp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, " valid"}, 64'(bus.sresp_valid), 64'd1);
    check({nm, " sresp"}, 64'(bus.sresp), 64'(er));
    check({nm, " sid"}, 64'(bus.sid), 64'(eid));
    check({nm, " serror"}, 64'(bus.serror), 64'(eerr));
    check({nm, " last"}, 64'(bus.sresp_last), 64'(elast));
    if (chk_data) check({nm, " sdata"}, 64'(bus.sdata), 64'(edata));
    bus.mresp_accept = 1'b1;
    @(posedge clk);
    #1 bus.mresp_accept = 1'b0;
  endtask

  task automatic read_beat(input string nm, input logic [3:0] eid, input logic eerr,
                           input logic elast, input logic [31:0] edata);
    recv_beat(nm, PZCOREBUS_RESPONSE_WITH_DATA, eid, eerr, elast, 1'b1, edata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;

    vecs[0] = '{1'b1, waddr(0),        4'hF, 32'h1122_3344, 4'd1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, waddr(0),        4'hF, 32'h0,         4'd2, 1'b0, 32'h1122_3344};
    vecs[2] = '{1'b1, waddr(0),        4'h5, 32'hAABB_CCDD, 4'd3, 1'b0, 32'h0};
    vecs[3] = '{1'b0, waddr(0),        4'hF, 32'h0,         4'd4, 1'b0, 32'h11BB_33DD};
    vecs[4] = '{1'b1, waddr(5),        4'hF, 32'hDEAD_BEEF, 4'd7, 1'b0, 32'h0};
    vecs[5] = '{1'b0, waddr(5),        4'hF, 32'h0,         4'd2, 1'b0, 32'hDEAD_BEEF};
    vecs[6] = '{1'b1, BASE + 32'h40,   4'hF, 32'h0BAD_0BAD, 4'd9, 1'b1, 32'h0};
    vecs[7] = '{1'b0, waddr(0),        4'hF, 32'h0,         4'd5, 1'b0, 32'h11BB_33DD};
    vecs[8] = '{1'b0, BASE + 32'h40,   4'hF, 32'h0,         4'd6, 1'b1, 32'h0};
    vecs[9] = '{1'b0, BASE - 32'h4,    4'hF, 32'h0,         4'd8, 1'b1, 32'h0};

    bus.mcmd_valid = 1'b0; bus.mcmd = PZCOREBUS_NULL_COMMAND; bus.mid = '0;
    bus.maddr = '0; bus.mlength = '0; bus.mdata_valid = 1'b0; bus.mdata = '0;
    bus.mdata_byteenable = '0; bus.mdata_last = 1'b0; bus.mresp_accept = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst scmd_accept", 64'(bus.scmd_accept), 64'd1);
    check("rst sdata_accept", 64'(bus.sdata_accept), 64'd0);
    check("rst sresp_valid", 64'(bus.sresp_valid), 64'd0);
    check("rst sresp", 64'(bus.sresp), 64'd0);
    check("rst sdata", 64'(bus.sdata), 64'd0);
    check("rst sresp_last", 64'(bus.sresp_last), 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].wr) begin
        send_cmd(PZCOREBUS_WRITE_NON_POSTED, vecs[i].addr, 4'd1, vecs[i].id);
        send_data(vecs[i].wdata, vecs[i].be, 1'b1);
        recv_beat($sformatf("vec%0d wr", i), PZCOREBUS_RESPONSE, vecs[i].id,
                  vecs[i].exp_err, 1'b1, 1'b0, 32'h0);
      end else begin
        send_cmd(PZCOREBUS_READ, vecs[i].addr, 4'd1, vecs[i].id);
        read_beat($sformatf("vec%0d rd", i), vecs[i].id, vecs[i].exp_err, 1'b1, vecs[i].exp_data);
      end
    end

    // Posted 2-beat write, then read back
    send_cmd(PZCOREBUS_WRITE, BASE + 32'h10, 4'd2, 4'd1);
    send_data(32'h0000_A5A5, 4'hF, 1'b0);
    send_data(32'h0000_5A5A, 4'hF, 1'b1);
    @(negedge clk);
    check("posted no resp", 64'(bus.sresp_valid), 64'd0);
    check("posted idle", 64'(bus.scmd_accept), 64'd1);
    send_cmd(PZCOREBUS_READ, BASE + 32'h10, 4'd2, 4'd2);
    @(negedge clk);
    check("read latency1", 64'(bus.sresp_valid), 64'd1);
    read_beat("a5 b1", 4'd2, 1'b0, 1'b0, 32'h0000_A5A5);
    read_beat("a5 b2", 4'd2, 1'b0, 1'b1, 32'h0000_5A5A);

    // Burst ends on count without mdata_last
    send_cmd(PZCOREBUS_WRITE, waddr(8), 4'd2, 4'd0);
    send_data(32'h88, 4'hF, 1'b0);
    send_data(32'h99, 4'hF, 1'b0);
    @(negedge clk);
    check("count end idle", 64'(bus.scmd_accept), 64'd1);
    send_cmd(PZCOREBUS_READ, waddr(8), 4'd2, 4'd4);
    read_beat("cnt b1", 4'd4, 1'b0, 1'b0, 32'h88);
    read_beat("cnt b2", 4'd4, 1'b0, 1'b1, 32'h99);

    // Early mdata_last
    send_cmd(PZCOREBUS_WRITE, waddr(10), 4'd4, 4'd0);
    send_data(32'hAA, 4'hF, 1'b1);
    @(negedge clk);
    check("early last idle", 64'(bus.scmd_accept), 64'd1);
    send_cmd(PZCOREBUS_READ, waddr(10), 4'd1, 4'd5);
    read_beat("early rd", 4'd5, 1'b0, 1'b1, 32'hAA);

    // Non-posted single write with mid=3
    send_cmd(PZCOREBUS_WRITE_NON_POSTED, waddr(12), 4'd1, 4'd3);
    send_data(32'h12, 4'hF, 1'b1);
    recv_beat("np resp", PZCOREBUS_RESPONSE, 4'd3, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("np single resp", 64'(bus.sresp_valid), 64'd0);

    // Wrap at DEPTH-1
    send_cmd(PZCOREBUS_WRITE, waddr(15), 4'd3, 4'd0);
    send_data(32'h0000_000F, 4'hF, 1'b0);
    send_data(32'h1000_0000, 4'hF, 1'b0);
    send_data(32'h1000_0001, 4'hF, 1'b1);
    send_cmd(PZCOREBUS_READ, waddr(15), 4'd3, 4'd6);
    read_beat("wrap b1", 4'd6, 1'b0, 1'b0, 32'h0000_000F);
    read_beat("wrap b2", 4'd6, 1'b0, 1'b0, 32'h1000_0000);
    read_beat("wrap b3", 4'd6, 1'b0, 1'b1, 32'h1000_0001);

    // Out-of-range read and write
    send_cmd(PZCOREBUS_READ, BASE + 32'h44, 4'd2, 4'd7);
    read_beat("oor b1", 4'd7, 1'b1, 1'b0, 32'h0);
    read_beat("oor b2", 4'd7, 1'b1, 1'b1, 32'h0);
    send_cmd(PZCOREBUS_WRITE, BASE + 32'h40, 4'd1, 4'd0);
    send_data(32'hFFFF_FFFF, 4'hF, 1'b1);
    send_cmd(PZCOREBUS_READ, waddr(0), 4'd1, 4'd8);
    read_beat("oor wr kept", 4'd8, 1'b0, 1'b1, 32'h1000_0000);

    // Stall on beat 2
    send_cmd(PZCOREBUS_WRITE, waddr(0), 4'd4, 4'd0);
    for (int i = 0; i < 4; i++) send_data(32'hC0 + 32'(i), 4'hF, i == 3);
    send_cmd(PZCOREBUS_READ, waddr(0), 4'd4, 4'd9);
    read_beat("stall b1", 4'd9, 1'b0, 1'b0, 32'hC0);
    held = 32'hC1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall hold valid c%0d", c), 64'(bus.sresp_valid), 64'd1);
      check($sformatf("stall hold data c%0d", c), 64'(bus.sdata), 64'(held));
      check($sformatf("stall hold last c%0d", c), 64'(bus.sresp_last), 64'd0);
    end
    read_beat("stall b2", 4'd9, 1'b0, 1'b0, 32'hC1);
    read_beat("stall b3", 4'd9, 1'b0, 1'b0, 32'hC2);
    read_beat("stall b4", 4'd9, 1'b0, 1'b1, 32'hC3);

    // Reset during beat 3 of an 8-beat read
    send_cmd(PZCOREBUS_READ, waddr(0), 4'd8, 4'd10);
    read_beat("rst b1", 4'd10, 1'b0, 1'b0, 32'hC0);
    read_beat("rst b2", 4'd10, 1'b0, 1'b0, 32'hC1);
    @(negedge clk);
    check("rst b3 present", 64'(bus.sresp_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst sresp_valid", 64'(bus.sresp_valid), 64'd0);
    check("midrst scmd_accept", 64'(bus.scmd_accept), 64'd1);
    send_cmd(PZCOREBUS_READ, waddr(5), 4'd1, 4'd11);
    read_beat("after rst", 4'd11, 1'b0, 1'b1, 32'h0000_5A5A);

    // Unsupported command
    send_cmd(PZCOREBUS_ATOMIC, waddr(2), 4'd4, 4'd12);
    read_beat("atomic", 4'd12, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    check("atomic one beat", 64'(bus.sresp_valid), 64'd0);

    // mlength=0 means MAX_LENGTH beats
    send_cmd(PZCOREBUS_READ, waddr(0), 4'd0, 4'd13);
    for (int b = 0; b < 16; b++) begin
      recv_beat($sformatf("max b%0d", b), PZCOREBUS_RESPONSE_WITH_DATA, 4'd13, 1'b0,
                b == 15, b < 4, 32'hC0 + 32'(b));
    end
    @(negedge clk);
    check("max done", 64'(bus.sresp_valid), 64'd0);

    // Data presented in IDLE is refused
    bus.mdata_valid = 1'b1;
    @(negedge clk);
    check("idle sdata_accept", 64'(bus.sdata_accept), 64'd0);
    bus.mdata_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
